// File: rtl/da_sched_pkg.sv
// Shared types and defaults for the DA FIR scheduler slice.
// Holds the FSM state type, default sizes and the id-width helper.
package da_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  localparam int NCH_DEF     = 4;
  localparam int TAPS_DEF    = 4;
  localparam int W_DEF       = 4;
  localparam int YW_DEF      = 7;
  localparam int TIMEOUT_DEF = 16;

  function automatic int cw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit from ptr upward.
// Ports: req[NCH], ptr[CW] in; grant one-hot[NCH], gnt_id[CW] out.
module rr_arbiter
  import da_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  localparam int CW = cw_of(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NCH; k++) begin
      // ptr < NCH, so one wrap subtract suffices
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/da_fir_scheduler.sv
// Round-robin scheduler sharing one bit-serial DA FIR engine among NCH
// channels. Ports: req_* (valid/ready/x), eng_* (start/x/done/y),
// res_* (valid/ready/ch/y), busy, sticky timeout_err; clk, async reset.
module da_fir_scheduler
  import da_sched_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int TAPS    = TAPS_DEF,
  parameter int W       = W_DEF,
  parameter int YW      = YW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int CW     = cw_of(NCH),
  localparam int XW     = TAPS * W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH*XW-1:0] req_x,
  output logic              eng_start,
  output logic [XW-1:0]     eng_x,
  input  logic              eng_done,
  input  logic [YW-1:0]     eng_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CW-1:0]     res_ch,
  output logic [YW-1:0]     res_y,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNTW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [XW-1:0]   eng_x_q, eng_x_d;
  logic [YW-1:0]   res_y_q, res_y_d;
  logic [CW-1:0]   res_ch_q, res_ch_d;
  logic            res_valid_q, res_valid_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            terr_q, terr_d;

  logic [NCH-1:0]  grant;
  logic [CW-1:0]   gnt_id;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  // Offer only in IDLE; masked by reset so nothing is granted while held
  assign req_ready   = (state_q == IDLE && !reset) ? grant : '0;
  assign eng_start   = (state_q == LAUNCH);
  assign eng_x       = eng_x_q;
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_y       = res_y_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    eng_x_d     = eng_x_q;
    res_y_d     = res_y_q;
    res_ch_d    = res_ch_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    terr_d      = terr_q;
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          eng_x_d = req_x[gnt_id*XW +: XW];
          ch_d    = gnt_id;
          ptr_d   = (gnt_id == CW'(NCH - 1)) ?
                    '0 : gnt_id + CW'(1);
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNTW'(1);
        // done takes priority over an expiring counter
        if (eng_done) begin
          res_y_d     = eng_y;
          res_ch_d    = ch_q;
          res_valid_d = 1'b1;
          state_d     = DELIVER;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DELIVER: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ch_q        <= '0;
      eng_x_q     <= '0;
      res_y_q     <= '0;
      res_ch_q    <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      eng_x_q     <= eng_x_d;
      res_y_q     <= res_y_d;
      res_ch_q    <= res_ch_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
    end
  end

endmodule
